// File: rtl/runway_scheduler_pkg.sv
// Shared types and constants for the runway scheduler.
package runway_scheduler_pkg;

  localparam int ID_W_DEF = 4;
  localparam int NUM_RW   = 2;

  typedef enum logic {
    TAKEOFF = 1'b0,
    LANDING = 1'b1
  } runway_kind_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_t;

endpackage

// File: rtl/runway_tracker.sv
// Per-runway bookkeeping: occupancy, held plane ID, wake cooldown,
// occupancy timer and the sticky stuck flag.
module runway_tracker #(
  parameter int ID_W        = 4,
  parameter int COOLDOWN    = 8,
  parameter int OCC_TIMEOUT = 1000
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            grant_en,
  input  logic [ID_W-1:0] grant_id,
  input  logic            rel_en,
  input  logic [ID_W-1:0] rel_id,
  output logic            available,
  output logic            busy,
  output logic            stuck,
  output logic            rel_ok
);

  localparam int CD_W  = $clog2(COOLDOWN + 1);
  localparam int CNT_W = $clog2(OCC_TIMEOUT + 1);
  localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COOLDOWN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OCC_TIMEOUT);

  logic             occ_q, occ_d;
  logic [ID_W-1:0]  held_q, held_d;
  logic [CD_W-1:0]  cd_q, cd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stuck_q, stuck_d;

  // Only the plane actually holding an occupied runway may clear it.
  assign rel_ok    = rel_en && occ_q && (rel_id == held_q);
  assign available = !occ_q && (cd_q == '0);
  assign busy      = occ_q || (cd_q != '0);
  assign stuck     = stuck_q;

  // Next-state: age counters, then apply release, then a new grant.
  // A grant only lands on an available (unoccupied) runway, so it never
  // collides with a valid release on the same runway.
  always_comb begin
    occ_d   = occ_q;
    held_d  = held_q;
    cd_d    = cd_q;
    cnt_d   = cnt_q;
    stuck_d = stuck_q;
    if (cd_q != '0) cd_d = cd_q - 1'b1;
    if (occ_q) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_MAX) stuck_d = 1'b1;
    end
    if (rel_ok) begin
      occ_d   = 1'b0;
      stuck_d = 1'b0;
      cd_d    = CD_LOAD;
      cnt_d   = '0;
    end
    if (grant_en) begin
      occ_d  = 1'b1;
      held_d = grant_id;
      cnt_d  = '0;
    end
  end

  // Runway state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_q   <= 1'b0;
      held_q  <= '0;
      cd_q    <= '0;
      cnt_q   <= '0;
      stuck_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      held_q  <= held_d;
      cd_q    <= cd_d;
      cnt_q   <= cnt_d;
      stuck_q <= stuck_d;
    end
  end

endmodule

// File: rtl/runway_scheduler.sv
// Arbitrates takeoff/landing queue heads onto two runways and holds the
// clearance until the reply path accepts it.
module runway_scheduler
  import runway_scheduler_pkg::*;
#(
  parameter int ID_W        = ID_W_DEF,
  parameter int COOLDOWN    = 8,
  parameter int OCC_TIMEOUT = 1000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              takeoff_valid,
  input  logic [ID_W-1:0]   takeoff_id,
  output logic              takeoff_pop,
  input  logic              landing_valid,
  input  logic [ID_W-1:0]   landing_id,
  output logic              landing_pop,
  input  logic              emergency,
  output logic              grant_valid,
  output logic [ID_W-1:0]   grant_id,
  output logic              grant_runway,
  output logic              grant_landing,
  input  logic              grant_ready,
  input  logic              release_valid,
  input  logic              release_runway,
  input  logic [ID_W-1:0]   release_id,
  output logic              release_err,
  output logic [NUM_RW-1:0] runway_busy,
  output logic [NUM_RW-1:0] runway_stuck
);

  sched_state_t      state_q, state_d;
  runway_kind_t      kind_q, kind_d;
  runway_kind_t      last_q, last_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic              grw_q, grw_d;
  logic              err_q, err_d;

  logic [NUM_RW-1:0] avail, rel_ok, gnt_en;
  logic              cand_l, cand_t, win_land, sel;

  for (genvar g = 0; g < NUM_RW; g++) begin : g_rw
    runway_tracker #(
      .ID_W        (ID_W),
      .COOLDOWN    (COOLDOWN),
      .OCC_TIMEOUT (OCC_TIMEOUT)
    ) u_trk (
      .clock     (clock),
      .reset_n   (reset_n),
      .grant_en  (gnt_en[g]),
      .grant_id  (gid_d),
      .rel_en    (release_valid && (release_runway == 1'(g))),
      .rel_id    (release_id),
      .available (avail[g]),
      .busy      (runway_busy[g]),
      .stuck     (runway_stuck[g]),
      .rel_ok    (rel_ok[g])
    );
  end

  assign grant_valid   = (state_q == GRANT);
  assign grant_id      = gid_q;
  assign grant_runway  = grw_q;
  assign grant_landing = (kind_q == LANDING);
  assign release_err   = err_q;

  // Selection + FSM next state; pops fire combinationally in the winning cycle.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    last_d      = last_q;
    gid_d       = gid_q;
    grw_d       = grw_q;
    gnt_en      = '0;
    takeoff_pop = 1'b0;
    landing_pop = 1'b0;
    cand_l      = landing_valid;
    cand_t      = takeoff_valid && !emergency;
    // With both present, landing wins only if takeoff was served last.
    win_land    = cand_l && (!cand_t || (last_q == TAKEOFF));
    sel         = !avail[0];
    err_d       = release_valid && !rel_ok[release_runway];
    case (state_q)
      IDLE: begin
        if ((|avail) && (cand_l || cand_t)) begin
          landing_pop = win_land;
          takeoff_pop = !win_land;
          gid_d       = win_land ? landing_id : takeoff_id;
          grw_d       = sel;
          kind_d      = win_land ? LANDING : TAKEOFF;
          last_d      = win_land ? LANDING : TAKEOFF;
          gnt_en[sel] = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: if (grant_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, grant fields and release error pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      kind_q  <= TAKEOFF;
      last_q  <= TAKEOFF;
      gid_q   <= '0;
      grw_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      grw_q   <= grw_d;
      err_q   <= err_d;
    end
  end

endmodule
